uart_tx_packetizer: RTL and testbench

- Transmit-side UART serializer for the matrix-vector multiply datapath.
- Accepts one W_BUS-wide result word (the Y bus) per valid/ready handshake.
- Emits it on `tx` as N_WORDS back-to-back UART frames: start bit, BITS_PER_WORD data bits LSB-first, then idle-high padding/stop bits.
- Sits between the MVM output register and the `uo_out[0]` pin. It is the counterpart of the RX deserializer that assembles the K/X bus.

---
 rtl/uart_tx_packetizer.sv | 123 ++++++++++++
 tb/tb_uart_tx_packetizer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: UART transmit serializer for the MVM result (Y) bus.
// Each accepted W_BUS word goes out on tx as N_WORDS back-to-back frames.
// Each frame is a start bit (0), then the data bits LSB-first, then padding (1).
// Optional macro UART_TX_PARITY_EN: the first padding bit of each frame
// carries the even parity of that frame's data bits.
// Ports: clk, rst (sync, active-high), s_valid/s_ready/s_data (input
//        handshake), tx (serial line, idle high), busy (transfer active).
module uart_tx_packetizer #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE_TX   = 13,
    parameter int W_BUS            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_BUS-1:0] s_data,
    output logic             tx,
    output logic             busy
);

    localparam int N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int TOTAL   = N_WORDS * PACKET_SIZE_TX;
    localparam int BW      = $clog2(TOTAL + 1);
    localparam int PW      = $clog2(CLOCKS_PER_PULSE + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(TOTAL - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    if (CLOCKS_PER_PULSE < 1) begin : g_err_cpp
        $error("CLOCKS_PER_PULSE must be >= 1");
    end
    if (W_BUS % BITS_PER_WORD != 0) begin : g_err_bus
        $error("W_BUS must be a multiple of BITS_PER_WORD");
    end
`ifdef UART_TX_PARITY_EN
    if (PACKET_SIZE_TX < BITS_PER_WORD + 2) begin : g_err_pkt
        $error("PACKET_SIZE_TX must be >= BITS_PER_WORD+2 with parity");
    end
`else
    if (PACKET_SIZE_TX < BITS_PER_WORD + 1) begin : g_err_pkt
        $error("PACKET_SIZE_TX must be >= BITS_PER_WORD+1");
    end
`endif

    logic [0:0]       r_state;
    logic [TOTAL-1:0] r_shift;
    logic [BW-1:0]    r_bit;
    logic [PW-1:0]    r_pulse;
    logic             r_tx;
    logic [TOTAL-1:0] w_packet;
    logic             w_accept;

    // Whole packet laid out in transmission order, bit 0 first.
    always_comb begin
        w_packet = '1;
        for (int w = 0; w < N_WORDS; w++) begin
            w_packet[w*PACKET_SIZE_TX] = 1'b0;
            for (int i = 0; i < BITS_PER_WORD; i++) begin
                w_packet[w*PACKET_SIZE_TX+1+i] = s_data[w*BITS_PER_WORD+i];
            end
`ifdef UART_TX_PARITY_EN
            w_packet[w*PACKET_SIZE_TX+1+BITS_PER_WORD] =
                ^s_data[w*BITS_PER_WORD +: BITS_PER_WORD];
`endif
        end
    end

    assign s_ready  = (r_state == S_IDLE);
    assign busy     = (r_state == S_SEND);
    assign tx       = r_tx;
    assign w_accept = s_valid && s_ready;

    // Bit 0 goes straight into r_tx at the accepting edge, so the shift
    // register only ever holds the bits still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '1;
            r_bit   <= '0;
            r_pulse <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state <= S_SEND;
                        r_tx    <= w_packet[0];
                        r_shift <= {1'b1, w_packet[TOTAL-1:1]};
                        r_bit   <= '0;
                        r_pulse <= '0;
                    end
                end
                S_SEND: begin
                    if (r_pulse == PULSE_LAST) begin
                        r_pulse <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_bit   <= '0;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b1, r_shift[TOTAL-1:1]};
                        end
                    end else begin
                        r_pulse <= r_pulse + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer: directed self-checking bench for uart_tx_packetizer.
// Default config, plus a CPP=1 / 9-bit-frame instance when parity is off.
module tb_uart_tx_packetizer;

    localparam int CPP   = 4;
    localparam int PKT   = 13;
    localparam int TOTAL = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int lowcnt   = 0;

    always #5 clk = ~clk;

    uart_tx_packetizer #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(8),
        .PACKET_SIZE_TX(PKT),
        .W_BUS(16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .tx(tx),
        .busy(busy)
    );

`ifndef UART_TX_PARITY_EN
    logic        s_valid2 = 1'b0;
    logic        s_ready2;
    logic [15:0] s_data2 = '0;
    logic        tx2;
    logic        busy2;

    uart_tx_packetizer #(
        .CLOCKS_PER_PULSE(1),
        .BITS_PER_WORD(8),
        .PACKET_SIZE_TX(9),
        .W_BUS(16)
    ) u_dut2 (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid2),
        .s_ready(s_ready2),
        .s_data(s_data2),
        .tx(tx2),
        .busy(busy2)
    );
`endif

    always @(negedge clk) begin
        if (!s_ready) lowcnt <= lowcnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference frames, transmission order: v[b] is the b-th bit on the line.
    function automatic logic [TOTAL-1:0] frames(input logic [15:0] d);
        logic [TOTAL-1:0] v;
        logic [7:0]       byt;
        v = '1;
        for (int w = 0; w < 2; w++) begin
            byt = d[w*8 +: 8];
            v[w*PKT] = 1'b0;
            for (int i = 0; i < 8; i++) v[w*PKT+1+i] = byt[i];
`ifdef UART_TX_PARITY_EN
            v[w*PKT+9] = ^byt;
`endif
        end
        return v;
    endfunction

    // Present a word from #1 after an edge; return #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input string tag);
        int budget;
        budget = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!s_ready) check_eq({tag, "_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_eq({tag, "_start"}, {31'd0, tx}, 0);
    endtask

    // Sample each bit mid-pulse; returns #1 after the final edge of the transfer.
    task automatic collect(output logic [TOTAL-1:0] v);
        v = '0;
        for (int b = 0; b < TOTAL; b++) begin
            repeat (2) @(posedge clk);
            #1;
            v[b] = tx;
            repeat (2) @(posedge clk);
        end
        #1;
    endtask

    logic [TOTAL-1:0] got;
    logic [TOTAL-1:0] exp_hand;
    logic [15:0]      d1;
    logic [15:0]      d2;
    int               lows;

    initial begin
        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx", {31'd0, tx}, 1);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_ready", {31'd0, s_ready}, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer
        lowcnt = 0;
        send(16'hA53C, "basic");
        collect(got);
        check_eq("basic_frames", 32'(got), 32'(frames(16'hA53C)));
`ifndef UART_TX_PARITY_EN
        exp_hand = 26'b1111101001010_1111001111000;
        check_eq("basic_hand", 32'(got), 32'(exp_hand));
`endif
        check_eq("basic_lowcnt", lowcnt, 104);
        check_eq("basic_done_ready", {31'd0, s_ready}, 1);
        check_eq("basic_done_busy", {31'd0, busy}, 0);
        check_eq("basic_done_tx", {31'd0, tx}, 1);

        // Hold-off: s_valid stays up, s_data churns during SEND
        d1 = 16'h5A96;
        d2 = 16'hC3E1;
        send(d1, "hold1");
        s_valid = 1'b1;
        fork
            collect(got);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    s_data = 16'($urandom);
                end
                @(negedge clk);
                s_data = d2;
            end
        join
        check_eq("hold_frames1", 32'(got), 32'(frames(d1)));
        check_eq("hold_ready", {31'd0, s_ready}, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_eq("hold_accept2", {31'd0, s_ready}, 0);
        check_eq("hold_start2", {31'd0, tx}, 0);
        collect(got);
        check_eq("hold_frames2", 32'(got), 32'(frames(d2)));

        // Reset during data bit 3 of word 1
        send(16'hA53C, "mid");
        repeat (69) @(posedge clk);
        #1;
        check_eq("mid_bit17", {31'd0, tx}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_tx", {31'd0, tx}, 1);
        check_eq("mid_rst_ready", {31'd0, s_ready}, 1);
        check_eq("mid_rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (!tx) lows++;
        end
        check_eq("mid_no_lows", lows, 0);
        send(16'h00FF, "after");
        collect(got);
        check_eq("after_frames", 32'(got), 32'(frames(16'h00FF)));

        // Back-to-back transfers
        for (int n = 0; n < 10; n++) begin
            d1 = 16'($urandom);
            send(d1, "b2b");
            collect(got);
            check_eq("b2b_frames", 32'(got), 32'(frames(d1)));
            check_eq("b2b_idle_tx", {31'd0, tx}, 1);
            check_eq("b2b_idle_ready", {31'd0, s_ready}, 1);
        end

`ifdef UART_TX_PARITY_EN
        send(16'h0301, "par");
        collect(got);
        exp_hand = 26'b1110000000110_1111000000010;
        check_eq("par_hand", 32'(got), 32'(exp_hand));
`else
        // CPP=1, 9-bit frames
        s_valid2 = 1'b1;
        s_data2  = 16'hFFFF;
        @(posedge clk);
        #1;
        s_valid2 = 1'b0;
        got = '0;
        for (int b = 0; b < 18; b++) begin
            got[b] = tx2;
            @(posedge clk);
            #1;
        end
        check_eq("cpp1_bits", 32'(got[17:0]), 32'(18'h3FDFE));
        check_eq("cpp1_done_ready", {31'd0, s_ready2}, 1);
        check_eq("cpp1_done_tx", {31'd0, tx2}, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
